piece_fit_checker: RTL and testbench

//  Sequential successor to the combinational piece-cell table. Expands piece/rot/pos into 4 board cell indices.

---
 rtl/piece_fit_checker.sv | 206 ++++++++++++++++++++
 tb/tb_piece_fit_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_fit_checker.sv
// Sequential piece placement check: expand piece/rot/pos to 4 cell indices, bounds-check, read board RAM for collisions.
// Optional PFC_EARLY_EXIT_EN: the first occupied cell found stops the remaining board reads.
module piece_fit_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int IDX_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       piece,
    input  logic [1:0]       rot,
    input  logic [3:0]       pos_x,
    input  logic [4:0]       pos_y,
    output logic             brd_rd_en,
    output logic [IDX_W-1:0] brd_rd_addr,
    input  logic             brd_rd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_fit,
    output logic             rsp_oob,
    output logic [IDX_W-1:0] blk_1,
    output logic [IDX_W-1:0] blk_2,
    output logic [IDX_W-1:0] blk_3,
    output logic [IDX_W-1:0] blk_4,
    output logic [2:0]       width,
    output logic [2:0]       height,
    output logic [2:0]       blk_color
);

    localparam int CW = IDX_W + 4;

    typedef enum logic [2:0] {IDLE, CALC, RD, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       p_q;
    logic [1:0]       r_q;
    logic [3:0]       x_q;
    logic [4:0]       y_q;
    logic [IDX_W-1:0] blk_q [4];
    logic [IDX_W-1:0] c_idx [4];
    logic [15:0]      c_off;
    logic [1:0]       dx, dy, mx, my;
    logic [2:0]       c_w, c_h, c_color;
    logic             c_oob;
    logic [1:0]       cnt;
    logic             occupied, oob_q, hit;

    // One hex digit per cell, cell 1 in the top digit: digit = dx*4 + dy
    function automatic logic [15:0] offsets(input logic [2:0] p, input logic [1:0] r);
        logic [15:0] o;
        o = '0;
        unique case (p)
            3'd0, 3'd1: o = r[0] ? 16'h0123 : 16'h048C;
            3'd2:       o = 16'h0415;
            3'd3: begin
                unique case (r)
                    2'd0: o = 16'h4159;
                    2'd1: o = 16'h0125;
                    2'd2: o = 16'h0485;
                    default: o = 16'h4561;
                endcase
            end
            3'd4:       o = r[0] ? 16'h0156 : 16'h4815;
            3'd5:       o = r[0] ? 16'h4125 : 16'h0459;
            3'd6: begin
                unique case (r)
                    2'd0: o = 16'h4562;
                    2'd1: o = 16'h0159;
                    2'd2: o = 16'h0124;
                    default: o = 16'h0489;
                endcase
            end
            default: begin
                unique case (r)
                    2'd0: o = 16'h0126;
                    2'd1: o = 16'h1048;
                    2'd2: o = 16'h4560;
                    default: o = 16'h1598;
                endcase
            end
        endcase
        return o;
    endfunction

    always_comb begin
        c_off = offsets(p_q, r_q);
        mx = '0;
        my = '0;
        dx = '0;
        dy = '0;
        for (int i = 0; i < 4; i++) begin
            dx = c_off[15-4*i -: 2];
            dy = c_off[13-4*i -: 2];
            if (dx > mx) mx = dx;
            if (dy > my) my = dy;
            c_idx[i] = IDX_W'((CW'(y_q) + CW'(dy)) * CW'(BOARD_W)
                              + CW'(x_q) + CW'(dx));
        end
        c_w   = {1'b0, mx} + 3'd1;
        c_h   = {1'b0, my} + 3'd1;
        c_oob = (6'(x_q) + 6'(c_w) > 6'(BOARD_W)) ||
                (6'(y_q) + 6'(c_h) > 6'(BOARD_H));
        unique case (p_q)
            3'd0, 3'd1: c_color = 3'd7;
            3'd2:       c_color = 3'd5;
            3'd3:       c_color = 3'd4;
            3'd4:       c_color = 3'd3;
            3'd5:       c_color = 3'd2;
            3'd6:       c_color = 3'd1;
            default:    c_color = 3'd6;
        endcase
    end

    assign hit = brd_rd_en & brd_rd_data;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req_valid) state_nx = CALC;
            CALC: state_nx = c_oob ? DONE : RD;
            RD: begin
                if (cnt == 2'd3) state_nx = WAIT;
`ifdef PFC_EARLY_EXIT_EN
                if (hit) state_nx = WAIT;
`endif
            end
            WAIT: state_nx = DONE;
            DONE: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_fit   = rsp_valid & ~occupied & ~oob_q;
    assign rsp_oob   = rsp_valid & oob_q;
    assign blk_1     = blk_q[0];
    assign blk_2     = blk_q[1];
    assign blk_3     = blk_q[2];
    assign blk_4     = blk_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            p_q         <= '0;
            r_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            for (int i = 0; i < 4; i++) blk_q[i] <= '0;
            width       <= '0;
            height      <= '0;
            blk_color   <= '0;
            oob_q       <= 1'b0;
            occupied    <= 1'b0;
            cnt         <= '0;
            brd_rd_en   <= 1'b0;
            brd_rd_addr <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        p_q      <= piece;
                        r_q      <= rot;
                        x_q      <= pos_x;
                        y_q      <= pos_y;
                        occupied <= 1'b0;
                    end
                end
                CALC: begin
                    for (int i = 0; i < 4; i++) blk_q[i] <= c_idx[i];
                    width     <= c_w;
                    height    <= c_h;
                    blk_color <= c_color;
                    oob_q     <= c_oob;
                    if (!c_oob) begin
                        brd_rd_en   <= 1'b1;
                        brd_rd_addr <= c_idx[0];
                        cnt         <= 2'd1;
                    end
                end
                RD: begin
                    // Data arriving now belongs to the read issued last cycle
                    occupied    <= occupied | hit;
                    brd_rd_addr <= blk_q[cnt];
                    cnt         <= cnt + 2'd1;
`ifdef PFC_EARLY_EXIT_EN
                    if (hit) begin
                        brd_rd_en   <= 1'b0;
                        brd_rd_addr <= '0;
                    end
`endif
                end
                WAIT: begin
                    occupied    <= occupied | hit;
                    brd_rd_en   <= 1'b0;
                    brd_rd_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_fit_checker.sv
// Scoreboard bench for piece_fit_checker: directed corner cases then random requests
// against a table-driven reference model and a behavioural board RAM.
module tb_piece_fit_checker;

    logic       clk, rst_n;
    logic       req_valid, req_ready;
    logic [2:0] piece;
    logic [1:0] rot;
    logic [3:0] pos_x;
    logic [4:0] pos_y;
    logic       brd_rd_en;
    logic [7:0] brd_rd_addr;
    logic       brd_rd_data;
    logic       rsp_valid, rsp_ready, rsp_fit, rsp_oob;
    logic [7:0] blk_1, blk_2, blk_3, blk_4;
    logic [2:0] width, height, blk_color;

    piece_fit_checker #(.BOARD_W(10), .BOARD_H(20), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .piece(piece), .rot(rot), .pos_x(pos_x), .pos_y(pos_y),
        .brd_rd_en(brd_rd_en), .brd_rd_addr(brd_rd_addr),
        .brd_rd_data(brd_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_fit(rsp_fit), .rsp_oob(rsp_oob),
        .blk_1(blk_1), .blk_2(blk_2), .blk_3(blk_3), .blk_4(blk_4),
        .width(width), .height(height), .blk_color(blk_color)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int fit, oob, b0, b1, b2, b3, w, h, col, lat;
    } exp_t;

    exp_t exp_q [$];
    time  acc_q [$];
    int   rd_q  [$];
    bit   board [256];
    bit   hold;
    int   errors = 0;
    int   checks = 0;

    // Cell offsets (dx,dy) x4 per [shape I,O,T,S,Z,J,L][rot]
    int tbl [7][4][8] = '{
        '{'{0,0,1,0,2,0,3,0}, '{0,0,0,1,0,2,0,3}, '{0,0,1,0,2,0,3,0}, '{0,0,0,1,0,2,0,3}},
        '{'{0,0,1,0,0,1,1,1}, '{0,0,1,0,0,1,1,1}, '{0,0,1,0,0,1,1,1}, '{0,0,1,0,0,1,1,1}},
        '{'{1,0,0,1,1,1,2,1}, '{0,0,0,1,0,2,1,1}, '{0,0,1,0,2,0,1,1}, '{1,0,1,1,1,2,0,1}},
        '{'{1,0,2,0,0,1,1,1}, '{0,0,0,1,1,1,1,2}, '{1,0,2,0,0,1,1,1}, '{0,0,0,1,1,1,1,2}},
        '{'{0,0,1,0,1,1,2,1}, '{1,0,0,1,0,2,1,1}, '{0,0,1,0,1,1,2,1}, '{1,0,0,1,0,2,1,1}},
        '{'{1,0,1,1,1,2,0,2}, '{0,0,0,1,1,1,2,1}, '{0,0,0,1,0,2,1,0}, '{0,0,1,0,2,0,2,1}},
        '{'{0,0,0,1,0,2,1,2}, '{0,1,0,0,1,0,2,0}, '{1,0,1,1,1,2,0,0}, '{0,1,1,1,2,1,2,0}}
    };
    int colors [8] = '{7, 7, 5, 4, 3, 2, 1, 6};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_fit"}, int'(rsp_fit), 0);
        chk({tag, "_rsp_oob"}, int'(rsp_oob), 0);
        chk({tag, "_rd_en"}, int'(brd_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(brd_rd_addr), 0);
        chk({tag, "_blks"}, int'(blk_1) + int'(blk_2) + int'(blk_3) + int'(blk_4), 0);
        chk({tag, "_wh_color"}, int'(width) + int'(height) + int'(blk_color), 0);
    endtask

    task automatic send(input int p, input int r, input int x, input int y);
        exp_t e;
        int   idx [4];
        int   kind, dx, dy, mw, mh, k, n, stop;
        kind = (p < 2) ? 0 : p - 1;
        mw = 0;
        mh = 0;
        for (int i = 0; i < 4; i++) begin
            dx = tbl[kind][r][2*i];
            dy = tbl[kind][r][2*i+1];
            if (dx > mw) mw = dx;
            if (dy > mh) mh = dy;
            idx[i] = ((y + dy) * 10 + x + dx) % 256;
        end
        e.w   = mw + 1;
        e.h   = mh + 1;
        e.oob = ((x + e.w > 10) || (y + e.h > 20)) ? 1 : 0;
        e.col = colors[p];
        e.b0 = idx[0]; e.b1 = idx[1]; e.b2 = idx[2]; e.b3 = idx[3];
        k = -1;
        if (e.oob == 0)
            for (int i = 0; i < 4; i++)
                if (k < 0 && board[idx[i]]) k = i;
        e.fit = (e.oob == 0 && k < 0) ? 1 : 0;
        e.lat = (e.oob != 0) ? 1 : 5;
`ifdef PFC_EARLY_EXIT_EN
        if (e.oob == 0 && k >= 0) e.lat = k + 3;
`endif
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", int'(req_ready), 1);
        req_valid = 1'b1;
        piece = 3'(p);
        rot   = 2'(r);
        pos_x = 4'(x);
        pos_y = 5'(y);
        @(posedge clk);
        acc_q.push_back($time);
        exp_q.push_back(e);
        stop = 0;
        if (e.oob == 0)
            for (int i = 0; i < 4; i++) begin
                if (stop == 0) rd_q.push_back(idx[i]);
`ifdef PFC_EARLY_EXIT_EN
                if (i == k) stop = 1;
`endif
            end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_drain", exp_q.size(), 0);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 256; i++) board[i] = 1'b0;
    endtask

    // Board RAM: answers the read held during this cycle by the next edge
    initial begin
        brd_rd_data = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && brd_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected_addr", int'(brd_rd_addr), -1);
                else chk("rd_addr", int'(brd_rd_addr), rd_q.pop_front());
                brd_rd_data = board[brd_rd_addr];
            end else begin
                brd_rd_data = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on first valid cycle, full compare at handshake
    initial begin
        bit   seen;
        time  t0;
        exp_t e;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (acc_q.size() == 0) chk("rsp_without_req", acc_q.size(), 1);
                    else begin
                        t0 = acc_q.pop_front();
                        if (exp_q.size() != 0)
                            chk("latency", int'(($time - t0) / 10), exp_q[0].lat);
                    end
                end
                if (rsp_ready) begin
                    seen = 0;
                    if (exp_q.size() == 0) chk("rsp_without_exp", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_fit", int'(rsp_fit), e.fit);
                        chk("rsp_oob", int'(rsp_oob), e.oob);
                        chk("blk_1", int'(blk_1), e.b0);
                        chk("blk_2", int'(blk_2), e.b1);
                        chk("blk_3", int'(blk_3), e.b2);
                        chk("blk_4", int'(blk_4), e.b3);
                        chk("width", int'(width), e.w);
                        chk("height", int'(height), e.h);
                        chk("color", int'(blk_color), e.col);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0;
        piece = '0;
        rot = '0;
        pos_x = '0;
        pos_y = '0;
        hold = 1'b0;
        clear_board();
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // T1..T4 directed
        send(3, 0, 0, 0);
        send(0, 0, 7, 0);
        send(0, 0, 6, 0);
        wait_idle();
        board[199] = 1'b1;
        send(7, 0, 8, 17);
        wait_idle();
        clear_board();
        board[1] = 1'b1;
        send(4, 0, 0, 0);
        send(4, 0, 0, 5);
        send(2, 1, 9, 0);
        send(1, 1, 0, 17);
        send(1, 1, 0, 16);
        wait_idle();
        clear_board();

        // T5: response held off for 10 cycles while junk requests are offered
        hold = 1'b1;
        send(3, 0, 0, 0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_valid_seen", int'(rsp_valid), 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_req_ready", int'(req_ready), 0);
            chk("stall_rsp_valid", int'(rsp_valid), 1);
            chk("stall_rsp_fit", int'(rsp_fit), exp_q[0].fit);
            chk("stall_blk_1", int'(blk_1), exp_q[0].b0);
            chk("stall_blk_4", int'(blk_4), exp_q[0].b3);
            req_valid = 1'b1;
            piece = 3'(i % 8);
            pos_x = 4'(i);
        end
        @(negedge clk);
        req_valid = 1'b0;
        hold = 1'b0;
        wait_idle();

        // T6: reset during the second board read
        send(3, 0, 0, 0);
        n = 0;
        while (n < 2) begin
            @(negedge clk);
            if (brd_rd_en) n++;
        end
        rst_n = 1'b0;
        #1;
        chk_reset("midrd");
        exp_q.delete();
        acc_q.delete();
        rd_q.delete();
        repeat (2) @(negedge clk);
        chk_reset("midrd_hold");
        rst_n = 1'b1;
        send(3, 0, 0, 0);
        wait_idle();

        // Random traffic, board reshuffled only while idle
        for (int j = 0; j < 200; j++) begin
            int dens;
            if (j % 8 == 0) begin
                wait_idle();
                dens = $urandom_range(0, 3);
                for (int c = 0; c < 256; c++)
                    board[c] = (dens != 0) && ($urandom_range(0, 3 * dens) == 0);
            end
            if ($urandom_range(0, 3) == 0)
                send($urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 15), $urandom_range(0, 31));
            else
                send($urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 9), $urandom_range(0, 19));
        end
        wait_idle();
        chk("reads_left_over", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
